sel_mux_pipe: RTL and testbench
===============================

# sel_mux_pipe

Parametrised N-way, W-bit selector for the pipeline datapath, generalising the fixed 3-way 32-bit operand mux into a registered stage with valid/ready flow control, a 2-entry skid buffer and flush. It sits between the forwarding/select logic and the next pipeline register. It gives one-cycle latency at full throughput while absorbing downstream stalls without a combinational ready path.

## Interface
- `N`, default 3: number of data sources, must be ≥ 2.
- `W`, default 32: data width, must be ≥ 1.
- `SEL_W`, default max(1, ceil(log2 N)): select width, derived and not overridden.
- `clk` in 1: sole clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_data` in N*W: packed sources, source k at bits [k*W +: W].
- `sel` in SEL_W: source index.
- `in_valid` in 1: upstream beat present.
- `in_ready` out 1: stage can accept; registered.
- `flush` in 1: discard all held beats.
- `out_data` out W: selected data.
- `out_valid` out 1: output beat present.
- `out_ready` in 1: downstream accepts.
- `bad_sel` out 1: present only with `SEL_MUX_PIPE_CHK_EN`.
- `bad_cnt` out 16: present only with `SEL_MUX_PIPE_CHK_EN`.

## Operation
- Selection: `sel` < N picks source `sel`. `sel` ≥ N picks source 0, which is the default branch.
- The selected word is captured on handshake, when `in_valid && in_ready` is high at the rising edge.
- Storage:
  - Primary register drives `out_data`/`out_valid`.
  - Skid register holds one beat when the primary is occupied and `out_ready` = 0.
- Occupancy states:
  - EMPTY: out_valid=0.
  - ONE: primary full.
  - TWO: primary and skid full.
- Transitions, with acc = in handshake and tak = `out_valid && out_ready`:
  - EMPTY + acc → ONE.
  - ONE + acc + !tak → TWO.
  - ONE + !acc + tak → EMPTY.
  - ONE + acc + tak → ONE, new data in primary.
  - TWO + tak → ONE, skid moves to primary.
  - Otherwise hold.
- `in_ready` is registered and equals 1 in EMPTY and ONE, and 0 in TWO. No acc can occur in TWO.
- Ordering is strict FIFO. No beat is duplicated or dropped except by flush.
- Flush has priority over everything:
  - Next state is EMPTY and `in_ready` goes to 1.
  - Any beat offered in the flush cycle is dropped.
  - A take in the flush cycle is still counted as delivered.
- Data registers are not cleared on flush. Only the valid flags are cleared.

## Timing
- Reset values: out_valid=0, out_data=0, in_ready=1, state EMPTY, bad_sel=0, bad_cnt=0.
- Reset acts immediately on assertion, mid-beat included. Held beats are lost.
- Latency: a beat accepted at edge t is visible on `out_data` after edge t, so one cycle.
- Throughput: one beat per cycle while `out_ready`=1.
- `out_data`/`out_valid` must remain stable while out_valid=1 and out_ready=0.
- There is no combinational path from `out_ready` to `in_ready`.

## Configuration
- `SEL_MUX_PIPE_CHK_EN` defined:
  - On every accepted beat with `sel` ≥ N, `bad_sel` is set sticky.
  - `bad_cnt` increments on each such beat and saturates at 16'hFFFF.
  - Both are cleared only by reset; flush does not clear them.
- `SEL_MUX_PIPE_CHK_EN` undefined: `bad_sel`/`bad_cnt` ports and their logic are absent. Datapath behaviour is identical.

## Structure
- Package `sel_mux_pkg` holds:
  - The occupancy state enum (EMPTY/ONE/TWO).
  - Default constants `SEL_MUX_DEF_N`=3 and `SEL_MUX_DEF_W`=32.
  - The counter width constant 16.
- Sub-module `skid_reg2`: generic W-bit 2-entry skid buffer holding the state, registers, ready logic and flush.
- The top contains the select decode, the range check and the optional checker.

## Test plan
- Reset, then N=3 W=32 with sources 0xA,0xB,0xC, sel=1, valid one cycle, out_ready=1 → out_data=0xB, out_valid=1 exactly one cycle later, then 0.
- Back-to-back sel 0,1,2,0 with out_ready=1 → outputs 0xA,0xB,0xC,0xA on consecutive cycles and in_ready stays 1.
- out_ready=0 with two beats 0xA,0xB → in_ready=0 after the second. out_data holds 0xA. Raise out_ready → 0xA then 0xB, and in_ready returns to 1.
- sel=3 with N=3 → out_data=0xA. With `SEL_MUX_PIPE_CHK_EN`, bad_sel=1 and bad_cnt=1; a second bad beat gives bad_cnt=2.
- State TWO with flush asserted and in_valid=1 → next cycle out_valid=0, in_ready=1, and the offered beat never appears.
- rst_n pulsed low asynchronously mid-stall in TWO → outputs go to reset values immediately, and the checker count is cleared.

Source files
------------

// File: rtl/sel_mux_pkg.sv
// Shared types and constants for the sel_mux_pipe selector stage and its skid buffer.
package sel_mux_pkg;

  localparam int SEL_MUX_DEF_N = 3;
  localparam int SEL_MUX_DEF_W = 32;
  localparam int SEL_MUX_CNT_W = 16;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } occ_e;

endpackage

// File: rtl/skid_reg2.sv
// Generic W-bit 2-entry skid buffer: primary drives the output, skid catches one beat
// during a stall so in_ready can stay a pure register.
module skid_reg2
  import sel_mux_pkg::*;
#(
  parameter int W = SEL_MUX_DEF_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready
);

  occ_e         state, state_nxt;
  logic [W-1:0] prim, skid;
  logic         acc, tak;
  logic         ld_prim, ld_skid, from_skid;

  assign acc       = in_valid && in_ready;
  assign tak       = out_valid && out_ready;
  assign out_valid = (state != OCC_EMPTY);
  assign out_data  = prim;

  always_comb begin
    state_nxt = state;
    ld_prim   = 1'b0;
    ld_skid   = 1'b0;
    from_skid = 1'b0;
    if (flush) begin
      state_nxt = OCC_EMPTY;
    end else begin
      case (state)
        OCC_EMPTY: if (acc) begin
          state_nxt = OCC_ONE;
          ld_prim   = 1'b1;
        end
        OCC_ONE: begin
          if (acc && !tak) begin
            state_nxt = OCC_TWO;
            ld_skid   = 1'b1;
          end else if (acc && tak) begin
            ld_prim   = 1'b1;
          end else if (tak) begin
            state_nxt = OCC_EMPTY;
          end
        end
        OCC_TWO: if (tak) begin
          // in_ready is low here, so no new beat can compete with the skid entry
          state_nxt = OCC_ONE;
          ld_prim   = 1'b1;
          from_skid = 1'b1;
        end
        default: state_nxt = OCC_EMPTY;
      endcase
    end
  end

  // Data words are only loaded, never cleared by flush; validity lives in state alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= OCC_EMPTY;
      prim     <= '0;
      skid     <= '0;
      in_ready <= 1'b1;
    end else begin
      state    <= state_nxt;
      in_ready <= (state_nxt != OCC_TWO);
      if (ld_prim) prim <= from_skid ? skid : in_data;
      if (ld_skid) skid <= in_data;
    end
  end

endmodule

// File: rtl/sel_mux_pipe.sv
// N-way W-bit registered selector with valid/ready, skid buffer and flush.
// Optional out-of-range select checker enabled by defining SEL_MUX_PIPE_CHK_EN.
module sel_mux_pipe
  import sel_mux_pkg::*;
#(
  parameter int N = SEL_MUX_DEF_N,
  parameter int W = SEL_MUX_DEF_W,
  localparam int SEL_W = (N > 2) ? $clog2(N) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N*W-1:0]   in_data,
  input  logic [SEL_W-1:0] sel,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             flush,
  output logic [W-1:0]     out_data,
  output logic             out_valid,
  input  logic             out_ready
`ifdef SEL_MUX_PIPE_CHK_EN
  , output logic                     bad_sel
  , output logic [SEL_MUX_CNT_W-1:0] bad_cnt
`endif
);

  logic [W-1:0] sel_word;

  // Out-of-range selects fall through to source 0.
  always_comb begin
    sel_word = in_data[W-1:0];
    for (int k = 1; k < N; k++)
      if (sel == SEL_W'(k)) sel_word = in_data[k*W +: W];
  end

  skid_reg2 #(.W(W)) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_data   (sel_word),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

`ifdef SEL_MUX_PIPE_CHK_EN
  logic sel_oob, bad_hit;

  assign sel_oob = ({1'b0, sel} >= (SEL_W+1)'(N));
  // A beat offered during flush is dropped, so it does not count as accepted.
  assign bad_hit = in_valid && in_ready && !flush && sel_oob;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bad_sel <= 1'b0;
      bad_cnt <= '0;
    end else if (bad_hit) begin
      bad_sel <= 1'b1;
      if (bad_cnt != '1) bad_cnt <= bad_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_sel_mux_pipe.sv
// Scoreboard bench for sel_mux_pipe (N=3, W=32); checker ports follow SEL_MUX_PIPE_CHK_EN.
module tb_sel_mux_pipe;
  localparam int N = 3;
  localparam int W = 32;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N*W-1:0] in_data;
  logic [1:0]     sel;
  logic           in_valid, in_ready, flush;
  logic [W-1:0]   out_data;
  logic           out_valid, out_ready;
`ifdef SEL_MUX_PIPE_CHK_EN
  logic           bad_sel;
  logic [15:0]    bad_cnt;
`endif

  always #5 clk = ~clk;

  sel_mux_pipe #(.N(N), .W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .sel       (sel),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .flush     (flush),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready)
`ifdef SEL_MUX_PIPE_CHK_EN
    , .bad_sel (bad_sel)
    , .bad_cnt (bad_cnt)
`endif
  );

  int n_chk = 0;
  int n_fail = 0;
  logic [W-1:0] sb_q[$];
  logic         prev_stall = 1'b0;
  logic [W-1:0] prev_data;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] ref_sel(input logic [N*W-1:0] d, input logic [1:0] s);
    if (s < 2'(N)) return d[s*W +: W];
    return d[W-1:0];
  endfunction

  // Called at the negedge with inputs set for the coming posedge; advances one cycle.
  task automatic step();
    logic acc, tak;
    if (prev_stall) begin
      chk("stall_valid", 32'(out_valid), 32'd1);
      chk("stall_data", out_data, prev_data);
    end
    chk("occ_valid", 32'(out_valid), 32'(sb_q.size() > 0));
    chk("occ_ready", 32'(in_ready), 32'(sb_q.size() < 2));
    acc = in_valid && in_ready;
    tak = out_valid && out_ready;
    if (tak) begin
      chk("sb_nonempty", 32'(sb_q.size() > 0), 32'd1);
      if (sb_q.size() > 0) chk("sb_data", out_data, sb_q.pop_front());
    end
    if (flush) sb_q.delete();
    else if (acc) sb_q.push_back(ref_sel(in_data, sel));
    prev_stall = out_valid && !out_ready && !flush;
    prev_data  = out_data;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1; sel = '0;
    in_data = {32'hC, 32'hB, 32'hA};
    @(negedge clk);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_data", out_data, 32'd0);
    chk("rst_ready", 32'(in_ready), 32'd1);
`ifdef SEL_MUX_PIPE_CHK_EN
    chk("rst_bad_sel", 32'(bad_sel), 32'd0);
    chk("rst_bad_cnt", 32'(bad_cnt), 32'd0);
`endif
    rst_n = 1'b1;
    @(negedge clk);

    // single beat, one-cycle latency
    sel = 2'd1; in_valid = 1'b1; step();
    in_valid = 1'b0;
    chk("lat_valid", 32'(out_valid), 32'd1);
    chk("lat_data", out_data, 32'hB);
    step();
    chk("lat_gone", 32'(out_valid), 32'd0);

    // back-to-back full throughput
    for (int i = 0; i < 4; i++) begin
      sel = 2'(i % 3); in_valid = 1'b1;
      chk("b2b_ready", 32'(in_ready), 32'd1);
      step();
    end
    idle(2);

    // stall fills the skid register
    out_ready = 1'b0;
    sel = 2'd0; in_valid = 1'b1; step();
    sel = 2'd1; step();
    chk("two_ready", 32'(in_ready), 32'd0);
    chk("two_data", out_data, 32'hA);
    idle(2);
    out_ready = 1'b1;
    step();
    chk("unstall_ready", 32'(in_ready), 32'd1);
    idle(2);
    chk("unstall_empty", 32'(sb_q.size()), 32'd0);

    // out-of-range select falls back to source 0
    sel = 2'd3; in_valid = 1'b1; step();
    in_valid = 1'b0;
    chk("oob_data", out_data, 32'hA);
`ifdef SEL_MUX_PIPE_CHK_EN
    chk("oob_bad_sel", 32'(bad_sel), 32'd1);
    chk("oob_bad_cnt1", 32'(bad_cnt), 32'd1);
    sel = 2'd3; in_valid = 1'b1; step();
    in_valid = 1'b0;
    chk("oob_bad_cnt2", 32'(bad_cnt), 32'd2);
`endif
    idle(2);

    // flush in TWO drops held and offered beats
    out_ready = 1'b0;
    sel = 2'd0; in_valid = 1'b1; step();
    sel = 2'd1; step();
    sel = 2'd2; flush = 1'b1; step();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_valid", 32'(out_valid), 32'd0);
    chk("flush_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b1;
    idle(3);

    // asynchronous reset mid-stall in TWO
    out_ready = 1'b0;
    sel = 2'd2; in_valid = 1'b1; step();
    sel = 2'd3; step();
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(out_valid), 32'd0);
    chk("arst_data", out_data, 32'd0);
    chk("arst_ready", 32'(in_ready), 32'd1);
`ifdef SEL_MUX_PIPE_CHK_EN
    chk("arst_bad_cnt", 32'(bad_cnt), 32'd0);
`endif
    sb_q.delete();
    prev_stall = 1'b0;
    @(negedge clk);
    rst_n = 1'b1; out_ready = 1'b1;
    @(negedge clk);

    // random traffic with stalls and occasional flush
    for (int i = 0; i < 300; i++) begin
      in_data   = {$urandom, $urandom, $urandom};
      sel       = 2'($urandom_range(0, 3));
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 24) == 0);
      step();
    end
    flush = 1'b0; out_ready = 1'b1; in_valid = 1'b0;
    for (int i = 0; i < 20 && sb_q.size() > 0; i++) step();
    chk("drain", 32'(sb_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
